// File: rtl/even_seq_checker.sv
// Receive-side monitor for the even-number generator bus: locks onto the +2 sequence
// and flags odd, skipped and repeated values. Optional build macro: EVEN_CHK_RESYNC_EN.
module even_seq_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 locked,
    output logic [WIDTH-1:0]     expected,
    output logic                 mismatch,
    output logic                 odd_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W:0] LOCK_RUN = (RUN_W + 1)'(LOCK_COUNT);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic [WIDTH-1:0]     expected_q, expected_d;
    logic                 locked_q, locked_d;
    logic                 mismatch_q, mismatch_d;
    logic                 odd_err_q, odd_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic [WIDTH-1:0] nxt;
    logic [RUN_W:0]   run_inc;
    logic             is_odd;
    logic             hit;

    assign nxt     = in_data + WIDTH'(2);
    assign run_inc = {1'b0, run_q} + 1'b1;
    assign is_odd  = in_data[0];
    assign hit     = (in_data == expected_q);

    always_comb begin
        // NOTE: every _d gets a default hold value first so no path through the case infers a latch.
        state_d     = state_q;
        run_d       = run_q;
        expected_d  = expected_q;
        err_count_d = err_count_q;
        mismatch_d  = 1'b0;
        odd_err_d   = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (is_odd) begin
                        odd_err_d = 1'b1;
                    end else begin
                        expected_d = nxt;
                        run_d      = RUN_W'(1);
                        state_d    = (LOCK_COUNT == 1) ? LOCKED : SYNC;
                    end
                end
                SYNC: begin
                    if (is_odd) begin
                        odd_err_d = 1'b1;
                        run_d     = '0;
                        state_d   = HUNT;
                    end else if (hit) begin
                        expected_d = nxt;
                        run_d      = run_inc[RUN_W-1:0];
                        if (run_inc == LOCK_RUN) state_d = LOCKED;
                    end else begin
                        expected_d = nxt;
                        run_d      = RUN_W'(1);
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        expected_d = nxt;
                    end else begin
                        mismatch_d  = 1'b1;
                        err_count_d = (&err_count_q) ? err_count_q : err_count_q + 1'b1;
                        if (is_odd) begin
                            odd_err_d = 1'b1;
                            run_d     = '0;
                            state_d   = HUNT;
                        end else begin
`ifdef EVEN_CHK_RESYNC_EN
                            // Treat the bad sample as the first of a new run.
                            expected_d = nxt;
                            run_d      = RUN_W'(1);
                            state_d    = (LOCK_COUNT == 1) ? LOCKED : SYNC;
`else
                            run_d   = '0;
                            state_d = HUNT;
`endif
                        end
                    end
                end
                default: begin
                    run_d   = '0;
                    state_d = HUNT;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q     <= HUNT;
            run_q       <= '0;
            expected_q  <= '0;
            locked_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            odd_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            expected_q  <= expected_d;
            locked_q    <= locked_d;
            mismatch_q  <= mismatch_d;
            odd_err_q   <= odd_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign expected  = expected_q;
    assign mismatch  = mismatch_q;
    assign odd_err   = odd_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_even_seq_checker.sv
// Bench for even_seq_checker: a streak-based reference model checked every cycle, plus
// directed scenarios with literal expectations. Follows EVEN_CHK_RESYNC_EN like the RTL.
module tb_even_seq_checker;

    localparam int LC  = 2;
    localparam int MOD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;

    logic       locked_a, mismatch_a, odd_err_a;
    logic [3:0] expected_a;
    logic [7:0] err_count_a;
    logic       locked_b, mismatch_b, odd_err_b;
    logic [3:0] expected_b;
    logic [1:0] err_count_b;

    even_seq_checker #(.WIDTH(4), .LOCK_COUNT(LC), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .locked(locked_a), .expected(expected_a), .mismatch(mismatch_a),
        .odd_err(odd_err_a), .err_count(err_count_a)
    );

    even_seq_checker #(.WIDTH(4), .LOCK_COUNT(LC), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .locked(locked_b), .expected(expected_b), .mismatch(mismatch_b),
        .odd_err(odd_err_b), .err_count(err_count_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: streak = consecutive correct evens seen (0 = hunting); locked once streak >= LC.
    int m_streak, m_exp, m_errs, m_d, m_nx;
    bit m_mism, m_odd;

    always @(posedge clk) begin
        m_mism = 1'b0;
        m_odd  = 1'b0;
        if (rst) begin
            m_streak = 0;
            m_exp    = 0;
            m_errs   = 0;
        end else if (in_valid) begin
            m_d  = int'(in_data);
            m_nx = (m_d + 2) % MOD;
            if (m_streak >= LC) begin
                if (m_d == m_exp) begin
                    m_exp = m_nx;
                end else begin
                    m_mism = 1'b1;
                    m_errs++;
                    if (m_d % 2 == 1) begin
                        m_odd    = 1'b1;
                        m_streak = 0;
                    end else begin
`ifdef EVEN_CHK_RESYNC_EN
                        m_exp    = m_nx;
                        m_streak = 1;
`else
                        m_streak = 0;
`endif
                    end
                end
            end else if (m_d % 2 == 1) begin
                m_odd    = 1'b1;
                m_streak = 0;
            end else if (m_streak == 0 || m_d != m_exp) begin
                m_exp    = m_nx;
                m_streak = 1;
            end else begin
                m_exp    = m_nx;
                m_streak = m_streak + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_locked",   int'(locked_a),    int'(m_streak >= LC));
            check("cmp_expected", int'(expected_a),  m_exp);
            check("cmp_mismatch", int'(mismatch_a),  int'(m_mism));
            check("cmp_odd_err",  int'(odd_err_a),   int'(m_odd));
            check("cmp_err_a",    int'(err_count_a), (m_errs > 255) ? 255 : m_errs);
            check("cmp_err_b",    int'(err_count_b), (m_errs > 3) ? 3 : m_errs);
            check("cmp_locked_b", int'(locked_b),    int'(m_streak >= LC));
        end
    end

    // Drive one cycle at a negedge; returns at the next negedge with outputs settled.
    task automatic step(input bit v, input int d);
        in_valid = v;
        in_data  = 4'(d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 0);
        rst = 1'b0;
    endtask

    int sat_b [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        do_reset();
        cmp_en = 1'b1;
        check("rst_locked", int'(locked_a), 0);
        check("rst_expected", int'(expected_a), 0);
        check("rst_err", int'(err_count_a), 0);

        // Clean stream with wrap.
        step(1'b1, 0);
        check("t1_locked0", int'(locked_a), 0);
        check("t1_exp0", int'(expected_a), 2);
        step(1'b1, 2);
        check("t1_locked1", int'(locked_a), 1);
        for (int v = 4; v <= 14; v += 2) step(1'b1, v);
        check("t1_wrap_exp", int'(expected_a), 0);
        step(1'b1, 0);
        step(1'b1, 2);
        check("t1_exp_end", int'(expected_a), 4);
        check("t1_err", int'(err_count_a), 0);

        // Skipped value.
        do_reset();
        for (int v = 0; v <= 6; v += 2) step(1'b1, v);
        step(1'b1, 10);
        check("t2_mism", int'(mismatch_a), 1);
        check("t2_err", int'(err_count_a), 1);
        check("t2_locked", int'(locked_a), 0);
        step(1'b1, 12);
`ifdef EVEN_CHK_RESYNC_EN
        check("t2_relock", int'(locked_a), 1);
        check("t2_relock_exp", int'(expected_a), 14);
`else
        check("t2_not_yet", int'(locked_a), 0);
        step(1'b1, 14);
        check("t2_relock", int'(locked_a), 1);
        check("t2_relock_exp", int'(expected_a), 0);
`endif

        // Odd value while locked, then odd while hunting.
        do_reset();
        step(1'b1, 0);
        step(1'b1, 2);
        step(1'b1, 7);
        check("t3_mism", int'(mismatch_a), 1);
        check("t3_odd", int'(odd_err_a), 1);
        check("t3_err", int'(err_count_a), 1);
        check("t3_locked", int'(locked_a), 0);
        step(1'b1, 3);
        check("t3_hunt_odd", int'(odd_err_a), 1);
        check("t3_hunt_mism", int'(mismatch_a), 0);
        check("t3_hunt_err", int'(err_count_a), 1);

        // Gaps in in_valid with garbage on the bus.
        do_reset();
        for (int v = 0; v <= 4; v += 2) step(1'b1, v);
        step(1'b1, 6);
        check("t4_exp8", int'(expected_a), 8);
        step(1'b0, 5);
        check("t4_gap_odd", int'(odd_err_a), 0);
        check("t4_gap_exp", int'(expected_a), 8);
        step(1'b0, 5);
        step(1'b1, 8);
        check("t4_exp10", int'(expected_a), 10);
        check("t4_mism", int'(mismatch_a), 0);
        check("t4_locked", int'(locked_a), 1);

        // Saturation of the narrow counter; also repeated value counts as mismatch.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 0);
            step(1'b1, 2);
            check("t5_locked", int'(locked_a), 1);
            step(1'b1, (k == 0) ? 2 : 8);
            check("t5_mism", int'(mismatch_a), 1);
            check("t5_err_b", int'(err_count_b), sat_b[k]);
            check("t5_err_a", int'(err_count_a), k + 1);
        end

        // Reset while locked with a nonzero count.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 0);
            step(1'b1, 2);
            step(1'b1, 8);
        end
        step(1'b1, 0);
        step(1'b1, 2);
        check("t6_pre_err", int'(err_count_a), 2);
        check("t6_pre_locked", int'(locked_a), 1);
        rst = 1'b1;
        step(1'b1, 4);
        check("t6_locked", int'(locked_a), 0);
        check("t6_exp", int'(expected_a), 0);
        check("t6_err", int'(err_count_a), 0);
        check("t6_pulses", int'(mismatch_a) + int'(odd_err_a), 0);
        rst = 1'b0;
        step(1'b1, 0);
        step(1'b1, 2);
        check("t6_relock", int'(locked_a), 1);
        check("t6_relock_exp", int'(expected_a), 4);

        step(1'b0, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
